simt_core: RTL

Parametrised SIMT execution core with a hardware reconvergence stack, a stalling load path and a ready/valid instruction handshake. It supersedes the fixed single-mask core. It sits between the fetch unit, which supplies `instr_in` for the current `pc_out`, and the per-thread memory ports. It executes one `gpu_isa_pkg::instruction_t` per accepted cycle across `NUM_THREADS` lanes.

---
 rtl/simt_core.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/simt_core.sv
// simt_core: SIMT execution core with lockstep lanes, a reconvergence stack and a stalling load path.
// Optional build macro SIMT_CORE_TID_INIT_EN: reset seeds r15 of each lane with its lane index.

package gpu_isa_pkg;
  localparam int unsigned OPC_W = 4;
  localparam int unsigned REG_W = 4;
  localparam int unsigned IMM_W = 16;

  localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd2;
  localparam logic [OPC_W-1:0] OP_MOV = 4'd3;
  localparam logic [OPC_W-1:0] OP_LDR = 4'd4;
  localparam logic [OPC_W-1:0] OP_STR = 4'd5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd6;
  localparam logic [OPC_W-1:0] OP_BEQ = 4'd7;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } instruction_t;
endpackage

module simt_core
  import gpu_isa_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned PC_WIDTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   instr_valid,
  input  instruction_t                           instr_in,
  output logic                                   instr_ready,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] mem_rdata,
  output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] mem_addr,
  output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] mem_wdata,
  output logic [NUM_THREADS-1:0]                 mem_we,
  output logic [NUM_THREADS-1:0]                 mem_re,
  output logic [PC_WIDTH-1:0]                    pc_out,
  output logic [NUM_THREADS-1:0]                 exec_mask_out,
  output logic                                   stack_ovf
);

  localparam int unsigned NREGS = 16;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LDWB = 2'd1,
    ST_POP  = 2'd2
  } state_e;

  state_e                                 r_state;
  state_e                                 w_state_nxt;
  logic [PC_WIDTH-1:0]                    r_pc;
  logic [NUM_THREADS-1:0]                 r_mask;
  logic [SP_W-1:0]                        r_sp;
  logic [PC_WIDTH-1:0]                    r_stk_rpc  [STACK_DEPTH];
  logic [NUM_THREADS-1:0]                 r_stk_mask [STACK_DEPTH];
  logic                                   r_ovf;
  logic [DATA_WIDTH-1:0]                  r_rf [NUM_THREADS][NREGS];
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] r_mem_addr;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] r_mem_wdata;
  logic [NUM_THREADS-1:0]                 r_mem_we;
  logic [NUM_THREADS-1:0]                 r_mem_re;
  logic [REG_W-1:0]                       r_ld_rd;
  logic [NUM_THREADS-1:0]                 r_ld_mask;

  logic [PC_WIDTH-1:0]                    w_tos_rpc;
  logic [NUM_THREADS-1:0]                 w_tos_mask;
  logic                                   w_match;
  logic [DATA_WIDTH-1:0]                  w_rs1_val [NUM_THREADS];
  logic [DATA_WIDTH-1:0]                  w_rs2_val [NUM_THREADS];
  logic [NUM_THREADS-1:0]                 w_taken;
  logic [PC_WIDTH-1:0]                    w_pc_nxt;
  logic [NUM_THREADS-1:0]                 w_mask_nxt;
  logic [SP_W-1:0]                        w_sp_nxt;
  logic                                   w_push;
  logic                                   w_ovf_nxt;
  logic [NUM_THREADS-1:0]                 w_rf_we;
  logic [REG_W-1:0]                       w_rf_waddr;
  logic [DATA_WIDTH-1:0]                  w_rf_wdata [NUM_THREADS];
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] w_mem_addr_nxt;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] w_mem_wdata_nxt;
  logic [NUM_THREADS-1:0]                 w_mem_we_nxt;
  logic [NUM_THREADS-1:0]                 w_mem_re_nxt;
  logic [REG_W-1:0]                       w_ld_rd_nxt;
  logic [NUM_THREADS-1:0]                 w_ld_mask_nxt;

  // Top-of-stack view; entry sp-1 is the most recent push.
  always_comb begin
    w_tos_rpc  = '0;
    w_tos_mask = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (r_sp == SP_W'(i + 1)) begin
        w_tos_rpc  = r_stk_rpc[i];
        w_tos_mask = r_stk_mask[i];
      end
    end
  end

  assign w_match     = (r_sp != '0) && (r_pc == w_tos_rpc);
  assign instr_ready = (r_state == ST_RUN) && !w_match;

  always_comb begin
    w_taken = '0;
    for (int t = 0; t < int'(NUM_THREADS); t++) begin
      w_rs1_val[t] = r_rf[t][instr_in.rs1];
      w_rs2_val[t] = r_rf[t][instr_in.rs2];
      w_taken[t]   = r_mask[t] && (w_rs1_val[t] == w_rs2_val[t]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_mask_nxt      = r_mask;
    w_sp_nxt        = r_sp;
    w_push          = 1'b0;
    w_ovf_nxt       = r_ovf;
    w_rf_we         = '0;
    w_rf_waddr      = instr_in.rd;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = '0;
    w_mem_re_nxt    = '0;
    w_ld_rd_nxt     = r_ld_rd;
    w_ld_mask_nxt   = r_ld_mask;
    for (int t = 0; t < int'(NUM_THREADS); t++) w_rf_wdata[t] = '0;

    case (r_state)
      ST_LDWB: begin
        w_rf_we     = r_ld_mask;
        w_rf_waddr  = r_ld_rd;
        for (int t = 0; t < int'(NUM_THREADS); t++) w_rf_wdata[t] = mem_rdata[t];
        w_state_nxt = ST_RUN;
      end
      ST_POP: begin
        w_mask_nxt  = w_tos_mask;
        w_sp_nxt    = r_sp - SP_W'(1);
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_match) begin
          w_state_nxt = ST_POP;
        end else if (instr_valid) begin
          w_pc_nxt = r_pc + PC_WIDTH'(1);
          case (instr_in.opcode)
            OP_ADD: begin
              w_rf_we = r_mask;
              for (int t = 0; t < int'(NUM_THREADS); t++) w_rf_wdata[t] = w_rs1_val[t] + w_rs2_val[t];
            end
            OP_SUB: begin
              w_rf_we = r_mask;
              for (int t = 0; t < int'(NUM_THREADS); t++) w_rf_wdata[t] = w_rs1_val[t] - w_rs2_val[t];
            end
            OP_MOV: begin
              w_rf_we = r_mask;
              for (int t = 0; t < int'(NUM_THREADS); t++) w_rf_wdata[t] = DATA_WIDTH'(instr_in.imm);
            end
            OP_STR: begin
              w_mem_we_nxt = r_mask;
              for (int t = 0; t < int'(NUM_THREADS); t++) begin
                w_mem_addr_nxt[t]  = w_rs1_val[t];
                w_mem_wdata_nxt[t] = w_rs2_val[t];
              end
            end
            OP_LDR: begin
              w_mem_re_nxt  = r_mask;
              w_ld_rd_nxt   = instr_in.rd;
              w_ld_mask_nxt = r_mask;
              w_state_nxt   = ST_LDWB;
              for (int t = 0; t < int'(NUM_THREADS); t++) w_mem_addr_nxt[t] = w_rs1_val[t];
            end
            OP_JMP: w_pc_nxt = PC_WIDTH'(instr_in.imm);
            OP_BEQ: begin
              // Uniform outcomes need no stack entry; only a split warp pushes.
              if (w_taken == r_mask) begin
                w_pc_nxt = PC_WIDTH'(instr_in.imm);
              end else if (w_taken != '0) begin
                if (r_sp < SP_W'(STACK_DEPTH)) begin
                  w_push     = 1'b1;
                  w_sp_nxt   = r_sp + SP_W'(1);
                  w_mask_nxt = r_mask & ~w_taken;
                end else begin
                  w_ovf_nxt = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_mask      <= '1;
      r_sp        <= '0;
      r_ovf       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= '0;
      r_mem_re    <= '0;
      r_ld_rd     <= '0;
      r_ld_mask   <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        r_stk_rpc[i]  <= '0;
        r_stk_mask[i] <= '0;
      end
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
        for (int r = 0; r < int'(NREGS); r++) r_rf[t][r] <= '0;
`ifdef SIMT_CORE_TID_INIT_EN
        r_rf[t][NREGS-1] <= DATA_WIDTH'(t);
`else
`endif
      end
    end else begin
      r_pc        <= w_pc_nxt;
      r_mask      <= w_mask_nxt;
      r_sp        <= w_sp_nxt;
      r_ovf       <= w_ovf_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_ld_rd     <= w_ld_rd_nxt;
      r_ld_mask   <= w_ld_mask_nxt;
      if (w_push) begin
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
          if (r_sp == SP_W'(i)) begin
            r_stk_rpc[i]  <= PC_WIDTH'(instr_in.imm);
            r_stk_mask[i] <= r_mask;
          end
        end
      end
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
        if (w_rf_we[t]) r_rf[t][w_rf_waddr] <= w_rf_wdata[t];
      end
    end
  end

  assign pc_out        = r_pc;
  assign exec_mask_out = r_mask;
  assign stack_ovf     = r_ovf;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_we        = r_mem_we;
  assign mem_re        = r_mem_re;

endmodule
